// File: rtl/set_vars_tx_if.sv
// Parameter-load link bundle: host request/data plus the serial frame
// lines toward the neuron's parameter receiver.
interface set_vars_tx_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic [DATA_W-1:0] tau_in;
  logic [DATA_W-1:0] weight_in;
  logic [DATA_W-1:0] threshold_in;
  logic              ready;
  logic              done;
  logic              set_vars;
  logic              expd;
  logic              w;
  logic              t;

  modport master (
    output start, tau_in, weight_in, threshold_in,
    input  ready, done, set_vars, expd, w, t
  );

  modport slave (
    input  start, tau_in, weight_in, threshold_in,
    output ready, done, set_vars, expd, w, t
  );
endinterface

// File: rtl/set_vars_tx.sv
// Serial transmitter for the neuron parameter-load link: latches tau/weight/
// threshold and shifts them out LSB-first on three lines under set_vars.
module set_vars_tx #(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  set_vars_tx_if.slave  bus
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam int IDX_W = $clog2(DATA_W);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    LEAD,
    SHIFT,
    GAP
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [GAP_W-1:0]  gap_q;
  logic [DATA_W-1:0] tau_q;
  logic [DATA_W-1:0] weight_q;
  logic [DATA_W-1:0] threshold_q;
  logic              ready_q;
  logic              done_q;
  logic              set_vars_q;
  logic              expd_q;
  logic              w_q;
  logic              t_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      gap_q       <= '0;
      tau_q       <= '0;
      weight_q    <= '0;
      threshold_q <= '0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      set_vars_q  <= 1'b0;
      expd_q      <= 1'b0;
      w_q         <= 1'b0;
      t_q         <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start && ready_q) begin
            tau_q       <= bus.tau_in;
            weight_q    <= bus.weight_in;
            threshold_q <= bus.threshold_in;
            ready_q     <= 1'b0;
            set_vars_q  <= 1'b1;
            expd_q      <= 1'b0;
            w_q         <= 1'b0;
            t_q         <= 1'b0;
            state_q     <= LEAD;
          end
        end
        // Lines stay low for one cycle so the receiver can clear its registers.
        LEAD: begin
          expd_q  <= tau_q[0];
          w_q     <= weight_q[0];
          t_q     <= threshold_q[0];
          cnt_q   <= CNT_W'(1);
          state_q <= SHIFT;
        end
        SHIFT: begin
          if (cnt_q == CNT_W'(DATA_W)) begin
            set_vars_q <= 1'b0;
            expd_q     <= 1'b0;
            w_q        <= 1'b0;
            t_q        <= 1'b0;
            gap_q      <= '0;
            state_q    <= GAP;
          end else begin
            expd_q <= tau_q[cnt_q[IDX_W-1:0]];
            w_q    <= weight_q[cnt_q[IDX_W-1:0]];
            t_q    <= threshold_q[cnt_q[IDX_W-1:0]];
            cnt_q  <= cnt_q + 1'b1;
          end
        end
        GAP: begin
          if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ready    = ready_q;
  assign bus.done     = done_q;
  assign bus.set_vars = set_vars_q;
  assign bus.expd     = expd_q;
  assign bus.w        = w_q;
  assign bus.t        = t_q;

endmodule
